// File: rtl/fp24_dot_acc_if.sv
// fp24_dot_acc_if: operand and result valid/ready bundle for fp24_dot_acc.
// Ports: in_valid/in_ready/a/b (operand side), out_valid/out_ready/dot (result side).
interface fp24_dot_acc_if #(
   parameter int N_TERMS = 3
);
   logic                      in_valid;
   logic                      in_ready;
   logic [N_TERMS-1:0][23:0]  a;
   logic [N_TERMS-1:0][23:0]  b;
   logic                      out_valid;
   logic                      out_ready;
   logic [23:0]               dot;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, dot
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, dot
   );
endinterface

// File: rtl/fp24_dot_acc.sv
// fp24_dot_acc: sequential fp24 dot product, one shared multiplier, one product per cycle.
// Ports: clk, rst (async, active-low), bus (fp24_dot_acc_if.slave). Macro FP24_DOT_CLAMP_EN
// clamps a negative final result to +0 on entry to DONE.
module fp24_mult (
   input  logic [23:0] x,
   input  logic [23:0] y,
   output logic [23:0] p
);
   logic        s;
   logic [33:0] prod;
   logic [15:0] mant;
   logic [8:0]  e_w;
   logic [8:0]  e_r;
   logic        unused_mul;

   always_comb begin
      s    = x[23] ^ y[23];
      prod = {17'b0, 1'b1, x[15:0]} * {17'b0, 1'b1, y[15:0]};
      mant = prod[33] ? prod[32:17] : prod[31:16];
      e_w  = {2'b0, x[22:16]} + {2'b0, y[22:16]} + {8'b0, prod[33]};
      e_r  = e_w - 9'd63;
      if (x[22:0] == 23'd0 || y[22:0] == 23'd0) begin
         p = '0;
      end else if (e_w < 9'd64) begin
         // biased exponent below 1: flush
         p = '0;
      end else if (e_w >= 9'd190) begin
         p = {s, 7'h7F, 16'h0};
      end else begin
         p = {s, e_r[6:0], mant};
      end
   end

   assign unused_mul = ^{prod[15:0], e_r[8:7]};
endmodule

module fp24_dot_acc #(
   parameter int N_TERMS = 3
) (
   input  logic          clk,
   input  logic          rst,
   fp24_dot_acc_if.slave bus
);
   localparam int IW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_TERMS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [23:0]              acc_q, acc_d;
   logic [N_TERMS-1:0][23:0] a_q, a_d;
   logic [N_TERMS-1:0][23:0] b_q, b_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;

   logic [23:0] prod;
   logic [23:0] sum;

   fp24_mult u_mult (
      .x (a_q[idx_q]),
      .y (b_q[idx_q]),
      .p (prod)
   );

   // accumulator adder: acc_q + prod, truncating
   logic [23:0] ox, oy;
   logic [6:0]  d;
   logic [18:0] fx, fy, diff, norm;
   logic [19:0] tot;
   logic [4:0]  lz;
   logic [7:0]  e_t;
   logic        unused_add;

   always_comb begin
      if (prod[22:0] > acc_q[22:0]) begin
         ox = prod;
         oy = acc_q;
      end else begin
         ox = acc_q;
         oy = prod;
      end
      d    = ox[22:16] - oy[22:16];
      fx   = {1'b1, ox[15:0], 2'b00};
      fy   = {1'b1, oy[15:0], 2'b00} >> d;
      tot  = {1'b0, fx} + {1'b0, fy};
      diff = fx - fy;
      lz   = '0;
      for (int i = 0; i < 19; i++) begin
         if (diff[i]) lz = 5'(18 - i);
      end
      norm = diff << lz;
      e_t  = tot[19] ? {1'b0, ox[22:16]} + 8'd1 : {1'b0, ox[22:16]};

      if (prod[22:0] == 23'd0) begin
         sum = acc_q;
      end else if (acc_q[22:0] == 23'd0) begin
         sum = prod;
      end else if (ox[22:16] == 7'h7F || oy[22:16] == 7'h7F) begin
         sum = {ox[23], 7'h7F, 16'h0};
      end else if (d >= 7'd19) begin
         sum = ox;
      end else if (ox[23] == oy[23]) begin
         if (e_t > 8'd127) begin
            sum = {ox[23], 7'h7F, 16'h0};
         end else begin
            sum = {ox[23], e_t[6:0], tot[19] ? tot[18:3] : tot[17:2]};
         end
      end else if (diff == 19'd0) begin
         sum = '0;
      end else if ({2'b0, lz} >= ox[22:16]) begin
         sum = '0;
      end else begin
         sum = {ox[23], ox[22:16] - {2'b0, lz}, norm[17:2]};
      end
   end

   assign unused_add = ^{norm[18], norm[1:0], tot[1:0]};

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.a;
               b_d        = bus.b;
               idx_d      = '0;
               acc_d      = '0;
               in_ready_d = 1'b0;
               state_d    = S_ACC;
            end
         end
         S_ACC: begin
            acc_d = sum;
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST) begin
               idx_d       = '0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
`ifdef FP24_DOT_CLAMP_EN
               // Lambertian clamp, final sum only
               if (sum[23]) acc_d = '0;
`endif
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.dot       = acc_q;
endmodule

// File: tb/tb_fp24_dot_acc.sv
// tb_fp24_dot_acc: directed scoreboard bench for fp24_dot_acc.
// Stimulus pushes expected dot values; a monitor pops them on each result handshake.
module tb_fp24_dot_acc;
   localparam int N = 3;
   typedef logic [N-1:0][23:0] vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fp24_dot_acc_if #(.N_TERMS(N)) bus ();

   fp24_dot_acc #(.N_TERMS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [23:0] sb[$];

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %06h want %06h", nm, act, exp);
      end
   endtask

   function automatic vec_t v3(input logic [23:0] x0, x1, x2);
      return {x2, x1, x0};
   endfunction

   // monitor: result transfers on the edge after a valid&&ready negedge sample
   initial begin
      forever begin
         @(negedge clk);
         if (rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_result: got %06h want none", bus.dot);
            end else begin
               chk("dot", bus.dot, sb.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // called at #1 after a posedge; returns #1 after the accept edge
   task automatic send(input vec_t va, input vec_t vb, input logic [23:0] exp);
      int w = 0;
      while (!bus.in_ready && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("in_ready_wait", {23'b0, bus.in_ready}, 24'd1);
      bus.a        = va;
      bus.b        = vb;
      bus.in_valid = 1'b1;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string nm);
      int lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 20);
      chk({nm, "_latency"}, 24'(lat), 24'(N));
   endtask

   task automatic run(input string nm, input vec_t va, input vec_t vb,
                      input logic [23:0] exp);
      send(va, vb, exp);
      wait_out(nm);
      @(posedge clk);
      #1;
      chk({nm, "_idle_ready"}, {23'b0, bus.in_ready}, 24'd1);
      chk({nm, "_idle_valid"}, {23'b0, bus.out_valid}, 24'd0);
   endtask

   logic [23:0] exp6;

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {23'b0, bus.out_valid}, 24'd0);
      chk("rst_in_ready", {23'b0, bus.in_ready}, 24'd1);
      chk("rst_dot", bus.dot, 24'h000000);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_in_ready", {23'b0, bus.in_ready}, 24'd1);

      run("t1_six", v3(24'h3F0000, 24'h400000, 24'h408000),
          v3(24'h3F0000, 24'h3F0000, 24'h3F0000), 24'h418000);
      run("t2_cancel", v3(24'h3F0000, 24'h3F0000, 24'h000000),
          v3(24'h3F0000, 24'hBF0000, 24'h408000), 24'h000000);
      run("t3_sat", v3(24'h7E0000, 24'h000000, 24'h000000),
          v3(24'h7E0000, 24'h000000, 24'h000000), 24'h7F0000);
      run("t3_flush", v3(24'h010000, 24'h000000, 24'h000000),
          v3(24'h010000, 24'h000000, 24'h000000), 24'h000000);
      run("norm", v3(24'h400000, 24'hBF0000, 24'h000000),
          v3(24'h3F0000, 24'h3F0000, 24'h3F0000), 24'h3F0000);
      run("far_exp", v3(24'h3F0000, 24'h2C0000, 24'h000000),
          v3(24'h3F0000, 24'h3F0000, 24'h000000), 24'h3F0000);
      run("mixed", v3(24'h408000, 24'hBF0000, 24'h400000),
          v3(24'h400000, 24'h408000, 24'hBF0000), 24'h3F0000);

      // backpressure hold in DONE
      bus.out_ready = 1'b0;
      send(v3(24'h3F0000, 24'h400000, 24'h408000),
           v3(24'h3F0000, 24'h3F0000, 24'h3F0000), 24'h418000);
      wait_out("t4");
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = 1'b1;
         bus.a        = v3(24'h400000, 24'h400000, 24'h400000);
         bus.b        = v3(24'h400000, 24'h400000, 24'h400000);
         @(posedge clk);
         #1;
         chk("t4_hold_valid", {23'b0, bus.out_valid}, 24'd1);
         chk("t4_hold_dot", bus.dot, 24'h418000);
         chk("t4_hold_ready", {23'b0, bus.in_ready}, 24'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_release_ready", {23'b0, bus.in_ready}, 24'd1);
      chk("t4_release_valid", {23'b0, bus.out_valid}, 24'd0);

      // reset mid-transaction
      send(v3(24'h3F0000, 24'h400000, 24'h408000),
           v3(24'h3F0000, 24'h3F0000, 24'h3F0000), 24'h418000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("t5_rst_valid", {23'b0, bus.out_valid}, 24'd0);
      chk("t5_rst_dot", bus.dot, 24'h000000);
      chk("t5_rst_ready", {23'b0, bus.in_ready}, 24'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_rel_ready", {23'b0, bus.in_ready}, 24'd1);
      chk("t5_rel_valid", {23'b0, bus.out_valid}, 24'd0);
      run("t5_again", v3(24'h3F0000, 24'h400000, 24'h408000),
          v3(24'h3F0000, 24'h3F0000, 24'h3F0000), 24'h418000);

`ifdef FP24_DOT_CLAMP_EN
      exp6 = 24'h000000;
`else
      exp6 = 24'hBF0000;
`endif
      run("t6_neg", v3(24'hBF0000, 24'h000000, 24'h000000),
          v3(24'h3F0000, 24'h000000, 24'h000000), exp6);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 24'(sb.size()), 24'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
